// File: rtl/regfile_write_queue.sv
// -----------------------------------------------------------------------------
// regfile_write_queue
//
// Write-side initiator for the 32 x DATA_WIDTH register file. Writeback
// requests are buffered in a small circular FIFO and retired to the regfile
// write port at one entry per cycle, so producers never stall on the single
// write port. Readers can forward from the queue: each lookup port returns
// the youngest queued entry whose destination matches.
//
// Ports
//   clk            in   clock, all state changes on posedge
//   reset          in   synchronous, active-high reset
//   in_valid       in   producer has a write request
//   in_ready       out  request accepted this cycle (registered state only)
//   in_reg         in   destination register (X31 requests are dropped)
//   in_data        in   destination data
//   RegWrite       out  regfile write enable (head entry present)
//   WriteRegister  out  regfile write address (0 when idle)
//   WriteData      out  regfile write data (0 when idle)
//   rd_reg1/2      in   forwarding lookup addresses
//   fwd_hit1/2     out  lookup matched a queued entry
//   fwd_data1/2    out  youngest matching queued data (0 when no hit)
//   count          out  number of queued entries, 0..DEPTH
// -----------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_reg,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    RegWrite,
    output logic [4:0]              WriteRegister,
    output logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [4:0]              rd_reg1,
    output logic                    fwd_hit1,
    output logic [DATA_WIDTH-1:0]   fwd_data1,
    input  logic [4:0]              rd_reg2,
    output logic                    fwd_hit2,
    output logic [DATA_WIDTH-1:0]   fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Control state
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Entry storage
    logic [4:0]            reg_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic push;
    logic pop;

    // in_ready depends only on registered state and reset, never on in_valid
    // or on the pop, so the producer sees no combinational loop through us.
    assign in_ready = !reset && (count_q != cnt_t'(DEPTH));

    // A handshake on X31 completes but stores nothing.
    assign push = in_valid && in_ready && (in_reg != 5'd31);

    // The head is retired every cycle it exists; the regfile has no backpressure.
    assign pop = !reset && (count_q != '0);

    assign RegWrite      = pop;
    assign WriteRegister = pop ? reg_q[head_q]  : '0;
    assign WriteData     = pop ? data_q[head_q] : '0;
    assign count         = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            head_d          = head_q + ptr_t'(1);
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            tail_d          = tail_q + ptr_t'(1);
            valid_d[tail_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; the valid bits and count decide what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail_q]  <= in_reg;
            data_q[tail_q] <= in_data;
        end
    end

    // Forwarding: scan from oldest (head) to youngest, so a later match
    // overwrites an earlier one and the youngest entry wins.
    always_comb begin
        ptr_t idx;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (!reset && valid_q[idx]) begin
                if (rd_reg1 != 5'd31 && reg_q[idx] == rd_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if (rd_reg2 != 5'd31 && reg_q[idx] == rd_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

endmodule
